// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception controller: cause codes, mem_exc_i flag
// positions, FSM state encoding and the default handler entry point.
package exc_ctrl_pkg;

  localparam logic [31:0] DefaultExcVector = 32'hBFC0_0380;

  // Bit positions inside mem_exc_i
  localparam int unsigned ExcAdelIf  = 0;
  localparam int unsigned ExcRi      = 1;
  localparam int unsigned ExcOv      = 2;
  localparam int unsigned ExcSyscall = 3;
  localparam int unsigned ExcBrk     = 4;
  localparam int unsigned ExcAdelLd  = 5;
  localparam int unsigned ExcAdes    = 6;
  localparam int unsigned ExcEret    = 7;

  // Codes handed to CP0 as excepttype
  localparam logic [4:0] CodeInt  = 5'h01;
  localparam logic [4:0] CodeAdel = 5'h04;
  localparam logic [4:0] CodeAdes = 5'h05;
  localparam logic [4:0] CodeSys  = 5'h08;
  localparam logic [4:0] CodeBp   = 5'h09;
  localparam logic [4:0] CodeRi   = 5'h0a;
  localparam logic [4:0] CodeOv   = 5'h0c;
  localparam logic [4:0] CodeEret = 5'h0e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFlush = 2'd1,
    StHold  = 2'd2
  } exc_state_e;

endpackage

// File: rtl/exc_prio.sv
// Fixed-priority exception encoder: a pending interrupt wins, eret loses to
// everything else.
module exc_prio
  import exc_ctrl_pkg::*;
(
  input  logic [7:0] exc_i,
  input  logic       int_pending_i,
  output logic       valid_o,
  output logic [4:0] code_o
);

  always_comb begin
    valid_o = 1'b1;
    code_o  = 5'd0;
    if (int_pending_i)               code_o = CodeInt;
    else if (exc_i[ExcAdelIf])       code_o = CodeAdel;
    else if (exc_i[ExcRi])           code_o = CodeRi;
    else if (exc_i[ExcOv])           code_o = CodeOv;
    else if (exc_i[ExcSyscall])      code_o = CodeSys;
    else if (exc_i[ExcBrk])          code_o = CodeBp;
    else if (exc_i[ExcAdelLd])       code_o = CodeAdel;
    else if (exc_i[ExcAdes])         code_o = CodeAdes;
    else if (exc_i[ExcEret])         code_o = CodeEret;
    else                             valid_o = 1'b0;
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception controller: synchronizes interrupts, picks the winning exception in
// MEM, issues a one-cycle flush to CP0, then holds off while the pipeline refills.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DefaultExcVector,
  parameter int unsigned HOLDOFF    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_i,
  input  logic        timer_int_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        mem_valid_i,
  input  logic        stall_i,
  input  logic [31:0] mem_pc_i,
  input  logic [31:0] mem_badaddr_i,
  input  logic        mem_in_delayslot_i,
  input  logic [7:0]  mem_exc_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] exc_pc_o,
  output logic [31:0] bad_addr_o,
  output logic        exc_delayslot_o,
  output logic [5:0]  int_sync_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  localparam int unsigned CntW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(HOLDOFF - 1);

  exc_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic [5:0]      sync1_q, sync2_q;
  logic [4:0]      code_q;
  logic [31:0]     exc_pc_q, bad_addr_q, new_pc_q;
  logic            delayslot_q, flush_q;

  logic       int_pending, prio_valid, detect;
  logic [4:0] prio_code;

  assign int_pending = status_i[0] & ~status_i[1] & (|(cause_i[15:8] & status_i[15:8]));
  assign detect      = (state_q == StIdle) & mem_valid_i & ~stall_i & prio_valid;

  exc_prio u_prio (
    .exc_i         (mem_exc_i),
    .int_pending_i (int_pending),
    .valid_o       (prio_valid),
    .code_o        (prio_code)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      code_q      <= '0;
      exc_pc_q    <= '0;
      bad_addr_q  <= '0;
      new_pc_q    <= '0;
      delayslot_q <= 1'b0;
      flush_q     <= 1'b0;
    end else begin
      sync1_q <= int_i;
      sync2_q <= sync1_q;
      unique case (state_q)
        StIdle: begin
          if (detect) begin
            state_q     <= StFlush;
            flush_q     <= 1'b1;
            code_q      <= prio_code;
            exc_pc_q    <= mem_pc_i;
            delayslot_q <= mem_in_delayslot_i;
            // adel_if faults on the fetch PC; data faults report the data address
            bad_addr_q  <= mem_exc_i[ExcAdelIf] ? mem_pc_i : mem_badaddr_i;
            new_pc_q    <= (prio_code == CodeEret) ? epc_i : EXC_VECTOR;
          end
        end
        StFlush: begin
          flush_q <= 1'b0;
          code_q  <= '0;
          cnt_q   <= '0;
          state_q <= (HOLDOFF == 0) ? StIdle : StHold;
        end
        StHold: begin
          if (cnt_q == CntLast) state_q <= StIdle;
          else                  cnt_q   <= cnt_q + CntW'(1);
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign excepttype_o    = {27'd0, code_q};
  assign exc_pc_o        = exc_pc_q;
  assign bad_addr_o      = bad_addr_q;
  assign exc_delayslot_o = delayslot_q;
  assign flush_o         = flush_q;
  assign new_pc_o        = new_pc_q;
  // Timer line is already synchronous; gated so outputs stay 0 in reset
  assign int_sync_o      = {sync2_q[5] | (timer_int_i & rst), sync2_q[4:0]};

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl with hand-computed expectations.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  int_i;
  logic        timer_int_i;
  logic [31:0] status_i, cause_i, epc_i;
  logic        mem_valid_i, stall_i;
  logic [31:0] mem_pc_i, mem_badaddr_i;
  logic        mem_in_delayslot_i;
  logic [7:0]  mem_exc_i;
  logic [31:0] excepttype_o, exc_pc_o, bad_addr_o, new_pc_o;
  logic        exc_delayslot_o, flush_o;
  logic [5:0]  int_sync_o;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  exc_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .int_i              (int_i),
    .timer_int_i        (timer_int_i),
    .status_i           (status_i),
    .cause_i            (cause_i),
    .epc_i              (epc_i),
    .mem_valid_i        (mem_valid_i),
    .stall_i            (stall_i),
    .mem_pc_i           (mem_pc_i),
    .mem_badaddr_i      (mem_badaddr_i),
    .mem_in_delayslot_i (mem_in_delayslot_i),
    .mem_exc_i          (mem_exc_i),
    .excepttype_o       (excepttype_o),
    .exc_pc_o           (exc_pc_o),
    .bad_addr_o         (bad_addr_o),
    .exc_delayslot_o    (exc_delayslot_o),
    .int_sync_o         (int_sync_o),
    .flush_o            (flush_o),
    .new_pc_o           (new_pc_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [7:0] exc, input logic [31:0] pc);
    mem_valid_i = 1'b1;
    mem_exc_i   = exc;
    mem_pc_i    = pc;
  endtask

  task automatic idle_in();
    mem_valid_i = 1'b0;
    mem_exc_i   = 8'h00;
  endtask

  // From the FLUSH cycle: two HOLD cycles, then IDLE
  task automatic back_to_idle();
    idle_in();
    repeat (3) step();
  endtask

  initial begin
    rst = 1'b0;
    int_i = 6'h3f;
    timer_int_i = 1'b1;
    status_i = 32'h0;
    cause_i = 32'h0;
    epc_i = 32'h0;
    mem_valid_i = 1'b0;
    stall_i = 1'b0;
    mem_pc_i = 32'h0;
    mem_badaddr_i = 32'h0;
    mem_in_delayslot_i = 1'b0;
    mem_exc_i = 8'h00;

    repeat (2) step();
    chk("rst_flush", {31'd0, flush_o}, 32'h0);
    chk("rst_type", excepttype_o, 32'h0);
    chk("rst_newpc", new_pc_o, 32'h0);
    chk("rst_intsync", {26'd0, int_sync_o}, 32'h0);
    int_i = 6'h05;
    timer_int_i = 1'b0;
    #2 rst = 1'b1;

    step();
    chk("sync_1st", {26'd0, int_sync_o}, 32'h00);
    step();
    chk("sync_2nd", {26'd0, int_sync_o}, 32'h05);
    timer_int_i = 1'b1;
    #1 chk("sync_timer", {26'd0, int_sync_o}, 32'h25);
    timer_int_i = 1'b0;
    int_i = 6'h00;
    repeat (2) step();

    // ov
    present(8'h04, 32'h8000_1000);
    mem_badaddr_i = 32'h0000_0abc;
    step();
    chk("ov_type", excepttype_o, 32'h0c);
    chk("ov_pc", exc_pc_o, 32'h8000_1000);
    chk("ov_flush", {31'd0, flush_o}, 32'h1);
    chk("ov_newpc", new_pc_o, 32'hBFC0_0380);
    chk("ov_ds", {31'd0, exc_delayslot_o}, 32'h0);
    idle_in();
    step();
    chk("ov_flush_1cyc", {31'd0, flush_o}, 32'h0);
    chk("ov_type_clr", excepttype_o, 32'h0);
    repeat (2) step();

    // eret + adel_if, in a delay slot
    present(8'h81, 32'h8000_0003);
    mem_in_delayslot_i = 1'b1;
    epc_i = 32'h1111_2222;
    step();
    chk("adelif_type", excepttype_o, 32'h04);
    chk("adelif_bad", bad_addr_o, 32'h8000_0003);
    chk("adelif_newpc", new_pc_o, 32'hBFC0_0380);
    chk("adelif_ds", {31'd0, exc_delayslot_o}, 32'h1);
    mem_in_delayslot_i = 1'b0;
    back_to_idle();

    // ri beats ov
    present(8'h06, 32'h8000_0010);
    step();
    chk("ri_type", excepttype_o, 32'h0a);
    back_to_idle();

    // syscall beats brk
    present(8'h18, 32'h8000_0014);
    step();
    chk("sys_type", excepttype_o, 32'h08);
    back_to_idle();

    // adel_ld reports data address
    present(8'h20, 32'h8000_0018);
    mem_badaddr_i = 32'h0000_1235;
    step();
    chk("adelld_type", excepttype_o, 32'h04);
    chk("adelld_bad", bad_addr_o, 32'h0000_1235);
    back_to_idle();

    // ades
    present(8'h40, 32'h8000_001c);
    mem_badaddr_i = 32'h0000_2002;
    step();
    chk("ades_type", excepttype_o, 32'h05);
    chk("ades_bad", bad_addr_o, 32'h0000_2002);
    back_to_idle();

    // interrupt: IE=1, EXL=0, IM2 & IP2
    status_i = 32'h0000_0401;
    cause_i  = 32'h0000_0400;
    present(8'h00, 32'h8000_0020);
    step();
    chk("int_type", excepttype_o, 32'h01);
    chk("int_flush", {31'd0, flush_o}, 32'h1);
    back_to_idle();

    // EXL set masks the interrupt
    status_i = 32'h0000_0403;
    present(8'h00, 32'h8000_0024);
    step();
    chk("exl_noflush", {31'd0, flush_o}, 32'h0);
    step();
    chk("exl_noflush2", {31'd0, flush_o}, 32'h0);
    status_i = 32'h0;
    cause_i  = 32'h0;
    idle_in();
    step();

    // eret alone, then a held syscall must wait out the holdoff
    epc_i = 32'h8000_2000;
    present(8'h80, 32'h8000_0030);
    step();
    chk("eret_type", excepttype_o, 32'h0e);
    chk("eret_newpc", new_pc_o, 32'h8000_2000);
    present(8'h08, 32'h8000_0034);
    step();
    chk("hold_ign1", {31'd0, flush_o}, 32'h0);
    step();
    chk("hold_ign2", {31'd0, flush_o}, 32'h0);
    step();
    chk("hold_idle", {31'd0, flush_o}, 32'h0);
    step();
    chk("hold_taken", {31'd0, flush_o}, 32'h1);
    chk("hold_type", excepttype_o, 32'h08);
    chk("hold_newpc", new_pc_o, 32'hBFC0_0380);
    back_to_idle();

    // syscall through a 3-cycle stall
    present(8'h08, 32'h8000_0040);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_noflush", {31'd0, flush_o}, 32'h0);
    end
    stall_i = 1'b0;
    step();
    chk("stall_taken", {31'd0, flush_o}, 32'h1);
    chk("stall_pc", exc_pc_o, 32'h8000_0040);
    back_to_idle();

    // reset during FLUSH
    present(8'h04, 32'h8000_0050);
    step();
    chk("prerst_flush", {31'd0, flush_o}, 32'h1);
    idle_in();
    #2 rst = 1'b0;
    #1;
    chk("midrst_flush", {31'd0, flush_o}, 32'h0);
    chk("midrst_type", excepttype_o, 32'h0);
    #1 rst = 1'b1;
    step();
    chk("postrst_flush", {31'd0, flush_o}, 32'h0);
    present(8'h10, 32'h8000_0060);
    step();
    chk("postrst_idle", {31'd0, flush_o}, 32'h1);
    chk("postrst_type", excepttype_o, 32'h09);
    idle_in();
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
